// File: rtl/half_dot_feeder_if.sv
// Handshake bundle between the half-precision dot-product feeder and its
// environment. master: the feeder itself. slave: the operand sources and the MAC.
interface half_dot_feeder_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             a_valid;
    logic [15:0]      a_data;
    logic             a_ready;
    logic             b_valid;
    logic [15:0]      b_data;
    logic             b_ready;
    logic             mac_ready;
    logic             mac_ivalid;
    logic             mac_control;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             res_valid;
    logic             cfg_err;

    modport master (
        input  start, cfg_len, a_valid, a_data, b_valid, b_data, mac_ready,
        output busy, a_ready, b_ready, mac_ivalid, mac_control,
        output mac_a, mac_b, res_valid, cfg_err
    );

    modport slave (
        output start, cfg_len, a_valid, a_data, b_valid, b_data, mac_ready,
        input  busy, a_ready, b_ready, mac_ivalid, mac_control,
        input  mac_a, mac_b, res_valid, cfg_err
    );
endinterface

// File: rtl/half_dot_feeder.sv
// Pairs FP16 A/B operand streams into one dot product of runtime length,
// drives the half-precision MAC inputs and flags the final-sum cycle.
// Ports: clock, resetn (async, active low), io (half_dot_feeder_if.master).
// Optional HALF_DOT_FEEDER_STALL_STATS_EN adds stall_cnt/vec_cnt outputs.
module half_dot_feeder #(
    parameter int LEN_W     = 8,
    parameter int LAT_TOTAL = 9
) (
    input  logic                clock,
    input  logic                resetn,
    half_dot_feeder_if.master   io
`ifdef HALF_DOT_FEEDER_STALL_STATS_EN
    ,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         vec_cnt
`endif
);
    localparam int DRN_W = $clog2(LAT_TOTAL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             mac_ivalid_q, mac_ivalid_d;
    logic             mac_control_q, mac_control_d;
    logic [15:0]      mac_a_q, mac_a_d;
    logic [15:0]      mac_b_q, mac_b_d;
    logic             res_valid_q, res_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             fire;

    // Both operands move together and only when the MAC can take them.
    assign fire = (state_q == FEED) && io.a_valid && io.b_valid && io.mac_ready;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        elem_cnt_d    = elem_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        mac_ivalid_d  = 1'b0;
        mac_control_d = 1'b0;
        mac_a_d       = mac_a_q;
        mac_b_d       = mac_b_q;
        res_valid_d   = 1'b0;
        cfg_err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    if (io.cfg_len != '0) begin
                        state_d    = FEED;
                        len_d      = io.cfg_len;
                        elem_cnt_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (fire) begin
                    mac_ivalid_d  = 1'b1;
                    mac_a_d       = io.a_data;
                    mac_b_d       = io.b_data;
                    mac_control_d = (elem_cnt_q == '0);
                    if (elem_cnt_q == len_q - LEN_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRN_W'(LAT_TOTAL);
                    end else begin
                        elem_cnt_d = elem_cnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                // res_valid is registered, so firing it at count 1 lands
                // it LAT_TOTAL cycles after the last mac_ivalid.
                if (drain_cnt_q == DRN_W'(1)) begin
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            len_q         <= '0;
            elem_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            mac_ivalid_q  <= 1'b0;
            mac_control_q <= 1'b0;
            mac_a_q       <= 16'h0000;
            mac_b_q       <= 16'h0000;
            res_valid_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            elem_cnt_q    <= elem_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            mac_ivalid_q  <= mac_ivalid_d;
            mac_control_q <= mac_control_d;
            mac_a_q       <= mac_a_d;
            mac_b_q       <= mac_b_d;
            res_valid_q   <= res_valid_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign io.busy        = (state_q != IDLE);
    assign io.a_ready     = fire;
    assign io.b_ready     = fire;
    assign io.mac_ivalid  = mac_ivalid_q;
    assign io.mac_control = mac_control_q;
    assign io.mac_a       = mac_a_q;
    assign io.mac_b       = mac_b_q;
    assign io.res_valid   = res_valid_q;
    assign io.cfg_err     = cfg_err_q;

`ifdef HALF_DOT_FEEDER_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        if ((state_q == FEED) && !io.mac_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (res_valid_d && (vec_cnt_q != 16'hFFFF))
            vec_cnt_d = vec_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 16'h0000;
            vec_cnt_q   <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign vec_cnt   = vec_cnt_q;
`endif
endmodule
